// File: rtl/increment_unit.sv
// Nock 4 (increment) reduction engine: reads a node, bumps its atomic tel and writes the result
// back into hed. Build option INCR_OVERFLOW_WRAP_EN makes an all-ones tel wrap to zero.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 32
`endif
`ifndef NOUN_WIDTH
`define NOUN_WIDTH 64
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 136
`endif
`ifndef GET_CONTENTS
`define GET_CONTENTS 2'd1
`endif
`ifndef SET_CONTENTS
`define SET_CONTENTS 2'd2
`endif
`ifndef ATOM_ATOM
`define ATOM_ATOM 2'b01
`endif

module increment_unit (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [`MEMORY_ADDR_WIDTH-1:0] module_address_in,
  input  logic [`MEMORY_DATA_WIDTH-1:0] module_data_in,
  input  logic                          mem_ready,
  input  logic [`MEMORY_DATA_WIDTH-1:0] read_data1,
  output logic                          mem_execute,
  output logic [`MEMORY_ADDR_WIDTH-1:0] address1,
  output logic [1:0]                    mem_func,
  output logic [`MEMORY_DATA_WIDTH-1:0] write_data,
  output logic                          module_finished,
  output logic [`MEMORY_ADDR_WIDTH-1:0] module_address,
  output logic [3:0]                    execute_return_sys_func,
  output logic [3:0]                    execute_return_state,
  output logic [7:0]                    error
);

  localparam int unsigned AddrW = `MEMORY_ADDR_WIDTH;
  localparam int unsigned DataW = `MEMORY_DATA_WIDTH;
  localparam int unsigned NounW = `NOUN_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StRead, StReadWait, StCheck, StWrite, StWriteWait, StDone, StErr
  } state_e;

  state_e             state_q, state_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [7:0]         tag_q, tag_d;
  logic [NounW-1:0]   tel_q, tel_d;
  logic [7:0]         error_q, error_d;

  logic [NounW-1:0]   sum;
  logic               overflow;
  logic [7:0]         tag_upd;
  logic               unused_in;

  // The caller's snapshot and the hed field are never needed: memory is authoritative.
  assign unused_in = ^{module_data_in, read_data1[2*NounW-1:NounW]};

  assign sum      = tel_q + NounW'(1);
  assign overflow = &tel_q;
  assign tag_upd  = {1'b0, tag_q[6:4], 2'b00, `ATOM_ATOM};
  assign error    = error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      tag_q   <= '0;
      tel_q   <= '0;
      error_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      tel_q   <= tel_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    addr_d                  = addr_q;
    tag_d                   = tag_q;
    tel_d                   = tel_q;
    error_d                 = error_q;
    mem_execute             = 1'b0;
    address1                = '0;
    mem_func                = 2'b00;
    write_data              = '0;
    module_finished         = 1'b0;
    module_address          = '0;
    execute_return_sys_func = 4'h0;
    execute_return_state    = 4'h0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = module_address_in;
          state_d = StRead;
        end
      end
      StRead: begin
        mem_execute = 1'b1;
        mem_func    = `GET_CONTENTS;
        address1    = addr_q;
        state_d     = StReadWait;
      end
      StReadWait: begin
        if (mem_ready) begin
          tag_d   = read_data1[DataW-1 -: 8];
          tel_d   = read_data1[NounW-1:0];
          state_d = StCheck;
        end
      end
      StCheck: begin
        // tag[0] set means tel is an atom; tag[7] marks the node as pending execution.
        if (!tag_q[0] || !tag_q[7]) begin
          error_d = 8'h01;
          state_d = StErr;
        end else begin
`ifdef INCR_OVERFLOW_WRAP_EN
          state_d = StWrite;
`else
          if (overflow) begin
            error_d = 8'h04;
            state_d = StErr;
          end else begin
            state_d = StWrite;
          end
`endif
        end
      end
      StWrite: begin
        mem_execute = 1'b1;
        mem_func    = `SET_CONTENTS;
        address1    = addr_q;
        write_data  = {tag_upd, sum, NounW'(0)};
        state_d     = StWriteWait;
      end
      StWriteWait: begin
        if (mem_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        module_finished         = 1'b1;
        module_address          = addr_q;
        execute_return_sys_func = 4'h2;
        execute_return_state    = 4'h2;
        state_d                 = StIdle;
      end
      StErr: begin
        module_finished         = 1'b1;
        execute_return_sys_func = 4'h3;
        execute_return_state    = 4'hF;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/increment_unit.md
INCREMENT_UNIT -- requirements
Module: increment_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  async active-low reset (reset rst, asynchronous, active-low; clock clk).
REQ-002 SHALL have ports: start  in  1  select from traversal (mux_controller == `MUX_INCR), level; module_address_in  in  `memory_addr_width  node address; module_data_in  in  `memory_data_width  node snapshot {tag,hed,tel}.
REQ-003 SHALL have memory ports: mem_ready  in  1; read_data1  in  `memory_data_width; mem_execute  out  1; address1  out  `memory_addr_width; mem_func  out  2; write_data  out  `memory_data_width.
REQ-004 SHALL have return ports: module_finished  out  1; module_address  out  `memory_addr_width; execute_return_sys_func  out  4; execute_return_state  out  4; error  out  8.

Function
REQ-005 SHALL implement Nock 4 reduction of a node whose hed is opcode `increment and whose tel (already evaluated) is an atom.
REQ-006 SHALL use FSM states IDLE, READ, READ_WAIT, CHECK, WRITE, WRITE_WAIT, DONE, ERR.
REQ-007 IDLE: on start=1, latch module_address_in, -> READ; module_data_in is informational only (memory is authoritative).
REQ-008 READ: address1=latched addr, mem_func=`GET_CONTENTS, mem_execute=1 for exactly one cycle, -> READ_WAIT.
REQ-009 READ_WAIT: mem_execute=0, mem_func=0 while waiting; on mem_ready latch read_data1, -> CHECK.
REQ-010 CHECK: if tag[0] (tel flag) = cell or tag[7] (execute bit) = 0 -> ERR with error=8'h01.
REQ-011 CHECK: sum = tel + 1 in `noun_width bits; overflow when tel is all-ones (see REQ-019).
REQ-012 WRITE: write_data = {tag', sum, `noun_width'0}, tag' = original tag with [7]=0, [3:2]=00, [1:0]=`ATOM_ATOM; mem_func=`SET_CONTENTS, mem_execute=1 one cycle.
REQ-013 WRITE_WAIT: deassert mem_execute/mem_func, clear address1/write_data to 0; on mem_ready -> DONE.
REQ-014 DONE: module_finished=1 one cycle, module_address=latched addr, execute_return_sys_func=4'h2 (TRAVERSE), execute_return_state=4'h2 (POP); -> IDLE.
REQ-015 ERR: module_finished=1 held, error held non-zero, execute_return_sys_func=4'h3, execute_return_state=4'hF; exits only by reset.
REQ-016 Latency, zero-wait memory (mem_ready the cycle after request): start to module_finished = 7 cycles.
REQ-017 start deasserting mid-operation SHALL NOT abort; start held high in DONE SHALL NOT retrigger until one IDLE cycle observed.
REQ-018 mem_ready arriving in IDLE/CHECK/DONE SHALL be ignored.

Configuration
REQ-019 Macro INCR_OVERFLOW_WRAP_EN: defined -> overflow writes sum=0, completes normally, error stays 0; undefined -> overflow goes to ERR with error=8'h04, no write issued.

Reset
REQ-020 rst=0 SHALL asynchronously force: state IDLE, mem_execute=0, mem_func=0, address1=0, write_data=0, module_finished=0, module_address=0, execute_return_sys_func=0, execute_return_state=0, error=0.
REQ-021 Reset mid-transaction SHALL drop mem_execute same edge; no write completes after reset release.

Verification
REQ-022 node @5 = {tag 8'h81, hed 4, tel 41}, start pulse -> write @5 {8'h01,42,0}, module_finished 1 cycle, return 2/2, module_address=5.
REQ-023 tel=0 -> write hed=1; mem_ready delayed 3 cycles on both accesses -> finished at cycle 11, mem_execute single pulse each.
REQ-024 tel all-ones: macro undefined -> error=8'h04, no SET_CONTENTS, return 3/F; macro defined -> hed=0 written, error=0.
REQ-025 tel flag = cell (tag 8'h80) -> error=8'h01, no write, module_finished held.
REQ-026 rst asserted in WRITE_WAIT -> all outputs 0 immediately; after release, idle until new start.
